// File: rtl/pulse_pkg.sv
// pulse_pkg: shared state encoding, default widths and pulse polarity for the pulse-train blocks
package pulse_pkg;
    typedef enum logic [1:0] {IDLE = 2'd0, PULSE = 2'd1, GAP = 2'd2, DONE = 2'd3} state_e;
    localparam int CNT_W_DEF = 4;
    localparam int GAP_W_DEF = 4;
    localparam logic PULSE_HIGH = 1'b1;
endpackage

// File: rtl/moore_pulse_gen_if.sv
// moore_pulse_gen_if: request/train bundle between a pulse-train requester and the generator
interface moore_pulse_gen_if
    import pulse_pkg::*;
#(
    parameter int CNT_W = CNT_W_DEF,
    parameter int GAP_W = GAP_W_DEF
);
    logic             start;
    logic [CNT_W-1:0] count;
    logic [GAP_W-1:0] gap;
    logic             pulse_out;
    logic             busy;
    logic             done;
    modport master (output start, count, gap, input pulse_out, busy, done);
    modport slave  (input start, count, gap, output pulse_out, busy, done);
endinterface

// File: rtl/pulse_gap_timer.sv
// pulse_gap_timer: loadable down-counter flagging that the current cycle is the last one
module pulse_gap_timer
    import pulse_pkg::*;
#(
    parameter int W = GAP_W_DEF
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         load_i,
    input  logic         en_i,
    input  logic [W-1:0] load_val_i,
    output logic         zero_next_o
);
    logic [W-1:0] ctr_q, ctr_d;
    always_comb ctr_d = load_i ? load_val_i : (en_i && ctr_q != '0) ? ctr_q - W'(1) : ctr_q;
    always_ff @(posedge clk) begin
        if (!rst) ctr_q <= '0;
        else      ctr_q <= ctr_d;
    end
    assign zero_next_o = ctr_q == W'(1);
endmodule

// File: rtl/moore_pulse_gen.sv
// moore_pulse_gen: emits count one-cycle pulses separated by gap low cycles, then a done strobe
module moore_pulse_gen
    import pulse_pkg::*;
#(
    parameter int CNT_W = CNT_W_DEF,
    parameter int GAP_W = GAP_W_DEF
) (
    input logic               clk,
    input logic               rst,
    moore_pulse_gen_if.slave  pg
);
    state_e           state_q, state_d;
    logic [CNT_W-1:0] rem_q, rem_d;
    logic [GAP_W-1:0] gap_len_q, gap_len_d;
    logic             gap_load, gap_en, gap_last;
    pulse_gap_timer #(.W(GAP_W)) u_gap (
        .clk         (clk),
        .rst         (rst),
        .load_i      (gap_load),
        .en_i        (gap_en),
        .load_val_i  (gap_len_q),
        .zero_next_o (gap_last)
    );
    always_comb begin
        state_d   = state_q;
        rem_d     = rem_q;
        gap_len_d = gap_len_q;
        gap_load  = 1'b0;
        gap_en    = 1'b0;
        case (state_q)
            IDLE: if (pg.start) begin
                rem_d     = pg.count;
                gap_len_d = (pg.gap == '0) ? GAP_W'(1) : pg.gap;
                state_d   = (pg.count != '0) ? PULSE : DONE;
            end
            PULSE: begin
                rem_d    = rem_q - CNT_W'(1);
                gap_load = rem_q != CNT_W'(1);
                state_d  = (rem_q == CNT_W'(1)) ? DONE : GAP;
            end
            GAP: begin
                gap_en  = 1'b1;
                state_d = gap_last ? PULSE : GAP;
            end
            DONE:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end
    always_ff @(posedge clk) begin
        if (!rst) begin
            state_q   <= IDLE;
            rem_q     <= '0;
            gap_len_q <= '0;
        end else begin
            state_q   <= state_d;
            rem_q     <= rem_d;
            gap_len_q <= gap_len_d;
        end
    end
    // Outputs depend on registered state only, so inputs never reach them combinationally
    assign pg.pulse_out = (state_q == PULSE) ? PULSE_HIGH : ~PULSE_HIGH;
    assign pg.done      = state_q == DONE;
    assign pg.busy      = state_q != IDLE;
endmodule

// File: tb/tb_moore_pulse_gen.sv
// tb_moore_pulse_gen: per-cycle expected {pulse_out,busy,done} queued by stimulus, checked by a monitor
module tb_moore_pulse_gen;
  logic clk = 1'b0;
  logic rst;
  logic stim_done = 1'b0;
  logic [2:0] exp_q[$];
  int checks = 0;
  int fails = 0;
  moore_pulse_gen_if #(.CNT_W(4), .GAP_W(4)) bus ();
  moore_pulse_gen dut (.clk(clk), .rst(rst), .pg(bus));
  always #5 clk = ~clk;
  localparam logic [2:0] IDL = 3'b000, PUL = 3'b110, GP = 3'b010, DN = 3'b011;
  logic [2:0] t2[8] = '{PUL, GP, GP, PUL, GP, GP, PUL, DN};
  logic [2:0] t3[4] = '{PUL, GP, PUL, DN};
  logic [2:0] t4[8] = '{PUL, GP, PUL, GP, PUL, GP, PUL, DN};
  task automatic step(input logic [2:0] e);
    exp_q.push_back(e);
    @(posedge clk);
    #2;
  endtask
  task automatic run_train(input logic [3:0] c, input logic [3:0] g);
    bus.count = c;
    bus.gap   = g;
    bus.start = 1'b1;
    step(IDL);
    bus.start = 1'b0;
    for (int i = 1; i <= int'(c); i++) begin
      step(PUL);
      if (i < int'(c)) repeat ((g == 4'd0) ? 1 : int'(g)) step(GP);
    end
    step(DN);
  endtask
  initial begin
    rst = 1'b0;
    bus.start = 1'b0;
    bus.count = '0;
    bus.gap = '0;
    repeat (2) @(posedge clk);
    #2;
    rst = 1'b1;
    repeat (10) step(IDL);
    checks++;
    if ({bus.pulse_out, bus.busy, bus.done} !== IDL) begin
      fails++;
      $display("FAIL idle after reset: got %b required %b", {bus.pulse_out, bus.busy, bus.done}, IDL);
    end
    bus.count = 4'd3;
    bus.gap = 4'd2;
    bus.start = 1'b1;
    step(IDL);
    bus.start = 1'b0;
    foreach (t2[i]) step(t2[i]);
    step(IDL);
    bus.count = 4'd2;
    bus.gap = 4'd0;
    bus.start = 1'b1;
    step(IDL);
    bus.start = 1'b0;
    foreach (t3[i]) step(t3[i]);
    step(IDL);
    bus.count = 4'd0;
    bus.gap = 4'd5;
    bus.start = 1'b1;
    step(IDL);
    bus.start = 1'b0;
    checks++;
    if ({bus.pulse_out, bus.busy, bus.done} !== DN) begin
      fails++;
      $display("FAIL count=0 done: got %b required %b", {bus.pulse_out, bus.busy, bus.done}, DN);
    end
    step(DN);
    step(IDL);
    step(IDL);
    bus.count = 4'd4;
    bus.gap = 4'd1;
    bus.start = 1'b1;
    step(IDL);
    for (int i = 0; i < 8; i++) begin
      bus.start = (i == 1 || i == 7);
      bus.count = bus.start ? 4'd9 : 4'd4;
      step(t4[i]);
    end
    bus.start = 1'b0;
    repeat (3) step(IDL);
    bus.count = 4'd15;
    bus.gap = 4'd15;
    bus.start = 1'b1;
    step(IDL);
    bus.start = 1'b0;
    step(PUL);
    repeat (15) step(GP);
    step(PUL);
    repeat (5) step(GP);
    rst = 1'b0;
    step(GP);
    checks++;
    if ({bus.pulse_out, bus.busy, bus.done} !== IDL) begin
      fails++;
      $display("FAIL mid-train reset: got %b required %b", {bus.pulse_out, bus.busy, bus.done}, IDL);
    end
    repeat (2) step(IDL);
    rst = 1'b1;
    repeat (5) step(IDL);
    run_train(4'd15, 4'd15);
    step(IDL);
    run_train(4'd1, 4'd7);
    step(IDL);
    stim_done = 1'b1;
  end
  initial begin
    logic [2:0] act, e;
    forever begin
      @(negedge clk);
      if (exp_q.size() != 0) begin
        e = exp_q.pop_front();
        act = {bus.pulse_out, bus.busy, bus.done};
        checks++;
        if (act !== e) begin
          fails++;
          $display("FAIL outputs at t=%0t: pulse/busy/done got %b required %b", $time, act, e);
        end
      end else if (stim_done) begin
        $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
        $finish;
      end
    end
  end
  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached, got no end required end");
    $fatal(1, "timeout");
  end
endmodule
